// File: rtl/ir_nec_pkg.sv
// NEC IR decoder shared definitions: FSM states and timing windows in microseconds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4
  } nec_state_e;

  localparam int          WIDTH_W   = 14;
  localparam logic [13:0] WIDTH_MAX = 14'd16383;

  // Leader mark (nominal 9000 us).
  localparam logic [13:0] LEAD_MARK_MIN  = 14'd8000;
  localparam logic [13:0] LEAD_MARK_MAX  = 14'd10000;
  // Leader space of a data frame (nominal 4500 us).
  localparam logic [13:0] LEAD_SPACE_MIN = 14'd4000;
  localparam logic [13:0] LEAD_SPACE_MAX = 14'd5000;
  // Leader space of a repeat frame (nominal 2250 us).
  localparam logic [13:0] RPT_SPACE_MIN  = 14'd2000;
  localparam logic [13:0] RPT_SPACE_MAX  = 14'd2500;
  // Bit mark and logic-0 space (nominal 560 us).
  localparam logic [13:0] BIT_MIN        = 14'd400;
  localparam logic [13:0] BIT_MAX        = 14'd700;
  // Logic-1 space (nominal 1690 us).
  localparam logic [13:0] ONE_MIN        = 14'd1400;
  localparam logic [13:0] ONE_MAX        = 14'd1900;

  // Inclusive window test on a measured width.
  function automatic logic in_window(input logic [13:0] w, input logic [13:0] lo,
                                     input logic [13:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes the IR line, strobes its edges and measures level widths in microseconds.
// Latency: edge strobes are combinational on the second sync flop (2 clk after the pin).
// Backpressure: none; free-running measurement.
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ir_i,
  output logic                rise_o,
  output logic                fall_o,
  output logic [WIDTH_W-1:0]  width_o
);

  localparam int DIV = (CLK_FREQ_HZ >= 2_000_000) ? (CLK_FREQ_HZ / 1_000_000) : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic               sync1_q, sync2_q, prev_q;
  logic [PW-1:0]      presc_q, presc_d, presc_base;
  logic [WIDTH_W-1:0] width_q, width_d, width_base;
  logic               edge_s, tick_s;

  assign edge_s  = sync2_q ^ prev_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;
  assign width_o = width_q;

  // Prescaler and saturating width counter. The strobe cycle is already counted as the
  // first cycle of the new level, so a level held N us reads exactly N at its closing edge.
  always_comb begin
    presc_base = edge_s ? '0 : presc_q;
    width_base = edge_s ? '0 : width_q;
    tick_s     = (presc_base == PRESC_LAST);
    presc_d    = tick_s ? '0 : presc_base + PW'(1);
    width_d    = (tick_s && (width_base != WIDTH_MAX)) ? width_base + 14'd1 : width_base;
  end

  // Synchronizer, edge history and counters; the line idles high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      presc_q <= '0;
      width_q <= '0;
    end else begin
      sync1_q <= ir_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      presc_q <= presc_d;
      width_q <= width_d;
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: leader/bit timing FSM, 32-bit shift, complement check, held outputs.
// Latency: code/repeat/error pulses 3 clk after the physical ir_input edge.
// Backpressure: none; events are single-cycle pulses that the consumer must catch.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_input,
  output logic       code_valid,
  output logic       repeat_pulse,
  output logic       frame_error,
  output logic [7:0] address,
  output logic [7:0] command
);

  localparam logic [13:0] TIMEOUT_W = 14'(TIMEOUT_US);

  logic               rise_s, fall_s;
  logic [WIDTH_W-1:0] width_s;

  nec_state_e  state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;
  logic        have_code_q, have_code_d;
  logic        cv_q, cv_d, rp_q, rp_d, fe_q, fe_d;

  logic        err_s, timeout_s, is_zero_s, is_one_s;
  logic [31:0] word_s;

  ir_pulse_timer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .ir_i    (ir_input),
    .rise_o  (rise_s),
    .fall_o  (fall_s),
    .width_o (width_s)
  );

  assign code_valid   = cv_q;
  assign repeat_pulse = rp_q;
  assign frame_error  = fe_q;
  assign address      = addr_q;
  assign command      = cmd_q;

  // Next-state logic: timeout has priority, then edge-driven window checks per state.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    have_code_d = have_code_q;
    cv_d        = 1'b0;
    rp_d        = 1'b0;
    fe_d        = 1'b0;
    err_s       = 1'b0;

    is_zero_s = in_window(width_s, BIT_MIN, BIT_MAX);
    is_one_s  = in_window(width_s, ONE_MIN, ONE_MAX);
    word_s    = {is_one_s, shreg_q[31:1]};
    timeout_s = (state_q != ST_IDLE) && (width_s >= TIMEOUT_W);

    if (timeout_s) begin
      err_s = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fall_s) state_d = ST_LEAD_MARK;
        end
        ST_LEAD_MARK: begin
          if (rise_s) begin
            if (in_window(width_s, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = ST_LEAD_SPACE;
            else                                                   err_s   = 1'b1;
          end
        end
        ST_LEAD_SPACE: begin
          if (fall_s) begin
            if (in_window(width_s, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              state_d  = ST_BIT_MARK;
              bitcnt_d = 5'd0;
            end else if (in_window(width_s, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
              // A repeat with no code decoded since reset has nothing to repeat.
              rp_d    = have_code_q;
              state_d = ST_IDLE;
            end else begin
              err_s = 1'b1;
            end
          end
        end
        ST_BIT_MARK: begin
          if (rise_s) begin
            if (is_zero_s) state_d = ST_BIT_SPACE;
            else           err_s   = 1'b1;
          end
        end
        ST_BIT_SPACE: begin
          if (fall_s) begin
            if (is_zero_s || is_one_s) begin
              shreg_d = word_s;
              if (bitcnt_q == 5'd31) begin
                // Falling edge of the stop mark closes the frame; its rising edge lands in IDLE.
                state_d = ST_IDLE;
                if ((word_s[15:8] == ~word_s[7:0]) && (word_s[31:24] == ~word_s[23:16])) begin
                  addr_d      = word_s[7:0];
                  cmd_d       = word_s[23:16];
                  have_code_d = 1'b1;
                  cv_d        = 1'b1;
                end else begin
                  err_s = 1'b1;
                end
              end else begin
                bitcnt_d = bitcnt_q + 5'd1;
                state_d  = ST_BIT_MARK;
              end
            end else begin
              err_s = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (err_s) begin
      fe_d    = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // State, datapath and output registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      addr_q      <= '0;
      cmd_q       <= '0;
      have_code_q <= 1'b0;
      cv_q        <= 1'b0;
      rp_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      have_code_q <= have_code_d;
      cv_q        <= cv_d;
      rp_q        <= rp_d;
      fe_q        <= fe_d;
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for ir_nec_decoder: drives NEC waveforms and scoreboards the pulse events.
// Latency: expects each event 3 clk after the driving ir_input edge.
// Backpressure: n/a.
module tb_ir_nec_decoder;

  localparam int K_CODE = 1;
  localparam int K_RPT  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int         kind;
    int         due;
    logic [7:0] addr;
    logic [7:0] cmd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ir_input;
  logic       code_valid, repeat_pulse, frame_error;
  logic [7:0] address, command;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   last_edge = 0;
  exp_t sb[$];
  logic [7:0] model_addr = 8'h00;
  logic [7:0] model_cmd  = 8'h00;

  // One tick per clock keeps microsecond timing cheap to simulate.
  ir_nec_decoder #(
    .CLK_FREQ_HZ(1_000_000),
    .TIMEOUT_US (12000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_input     (ir_input),
    .code_valid   (code_valid),
    .repeat_pulse (repeat_pulse),
    .frame_error  (frame_error),
    .address      (address),
    .command      (command)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive a level at the current negedge and hold it for dur cycles.
  task automatic seg(input logic lvl, input int dur);
    ir_input  = lvl;
    last_edge = cyc;
    repeat (dur) @(negedge clk);
  endtask

  // Record the event the edge about to be driven should produce.
  task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] c);
    exp_t e;
    if (kind == K_CODE) begin
      model_addr = a;
      model_cmd  = c;
    end
    e.kind = kind;
    e.due  = cyc + 3;
    e.addr = model_addr;
    e.cmd  = model_cmd;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] word, input int lm, input int ls, input int bm,
                            input int b0, input int b1, input int nbits, input int kind);
    seg(1'b0, lm);
    seg(1'b1, ls);
    for (int i = 0; i < nbits; i++) begin
      seg(1'b0, bm);
      seg(1'b1, word[i] ? b1 : b0);
    end
    if (nbits == 32) begin
      if (kind != 0) expect_ev(kind, word[7:0], word[23:16]);
      seg(1'b0, bm);
      seg(1'b1, 3000);
    end
  endtask

  task automatic send_repeat(input int mark, input int space, input int kind);
    seg(1'b0, mark);
    seg(1'b1, space);
    if (kind != 0) expect_ev(kind, model_addr, model_cmd);
    seg(1'b0, 560);
    seg(1'b1, 3000);
  endtask

  function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    int   kind;
    int   n;
    exp_t e;
    if (code_valid || repeat_pulse || frame_error) begin
      n    = int'(code_valid) + int'(repeat_pulse) + int'(frame_error);
      kind = frame_error ? K_ERR : (repeat_pulse ? K_RPT : K_CODE);
      chk("pulse_onehot", n, 1);
      if (sb.size() == 0) begin
        chk("spurious_pulse", kind, 0);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_latency", cyc, e.due);
        chk("ev_address", address, e.addr);
        chk("ev_command", command, e.cmd);
      end
    end
  end

  initial begin
    repeat (1_000_000) @(posedge clk);
    fails++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ir_input = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_repeat", repeat_pulse, 0);
    chk("rst_error", frame_error, 0);
    chk("rst_address", address, 8'h00);
    chk("rst_command", command, 8'h00);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Repeat with no prior code: silent.
    send_repeat(9000, 2250, 0);
    chk("t3_address", address, 8'h00);
    chk("t3_command", command, 8'h00);
    chk("t3_drain", sb.size(), 0);

    // Nominal frame 0x00 / 0x45.
    send_frame(nec_word(8'h00, 8'h45), 9000, 4500, 560, 560, 1690, 32, K_CODE);
    chk("t1_address", address, 8'h00);
    chk("t1_command", command, 8'h45);
    chk("t1_drain", sb.size(), 0);

    // Repeats at nominal, max and min windows; then a space just outside the repeat window.
    send_repeat(9000, 2250, K_RPT);
    send_repeat(10000, 2500, K_RPT);
    send_repeat(8000, 2000, K_RPT);
    send_repeat(9000, 2600, K_ERR);
    chk("t2_command", command, 8'h45);
    chk("t2_drain", sb.size(), 0);

    // Bad command complement (0x45 / 0xBB) at minimum timings: error, outputs held.
    send_frame({8'hBB, 8'h45, 8'hDD, 8'h22}, 8000, 4000, 400, 400, 1400, 32, K_ERR);
    chk("t4_address", address, 8'h00);
    chk("t4_command", command, 8'h45);
    chk("t4_drain", sb.size(), 0);

    // Bit space between the 0 and 1 windows.
    seg(1'b0, 8000);
    seg(1'b1, 4000);
    seg(1'b0, 560);
    seg(1'b1, 1000);
    expect_ev(K_ERR, model_addr, model_cmd);
    seg(1'b0, 560);
    seg(1'b1, 3000);
    chk("badbit_drain", sb.size(), 0);

    // Short leader mark errors at its rising edge; the next good frame decodes.
    seg(1'b0, 7000);
    expect_ev(K_ERR, model_addr, model_cmd);
    seg(1'b1, 5000);
    send_frame(nec_word(8'h10, 8'h18), 8000, 4000, 400, 400, 1400, 32, K_CODE);
    chk("t5_address", address, 8'h10);
    chk("t5_command", command, 8'h18);
    chk("t5_drain", sb.size(), 0);

    // Frame stops after 16 bits: timeout 12000 us after the last rising edge.
    send_frame(nec_word(8'h77, 8'h01), 8000, 4000, 560, 560, 1690, 16, 0);
    sb.push_back('{K_ERR, last_edge + 12003, model_addr, model_cmd});
    repeat (14000) @(negedge clk);
    chk("t6_address", address, 8'h10);
    chk("t6_drain", sb.size(), 0);

    // Reset in the middle of a frame clears outputs and the repeat history.
    send_frame(nec_word(8'h33, 8'h44), 9000, 4500, 560, 560, 1690, 10, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_address", address, 8'h00);
    chk("midrst_command", command, 8'h00);
    reset      = 1'b0;
    model_addr = 8'h00;
    model_cmd  = 8'h00;
    repeat (3000) @(negedge clk);
    send_repeat(9000, 2250, 0);
    chk("midrst_rpt_addr", address, 8'h00);
    send_frame(nec_word(8'h5A, 8'hC3), 10000, 5000, 700, 700, 1900, 32, K_CODE);
    chk("t7_address", address, 8'h5A);
    chk("t7_command", command, 8'hC3);

    repeat (50) @(negedge clk);
    chk("final_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
